// File: rtl/cpu_6502_ISA_pkg.sv
// cpu_6502_ISA_pkg -- shared 6502 ISA definitions for the fetch unit.
// Provides the addressing-mode and instruction-length types, the fetch FSM
// state type, the reset-vector addresses, the jump opcodes and a helper that
// recognises the single-byte implied opcodes.
// Build option: CPU_6502_FETCH_RESET_VECTOR_EN adds the reset-vector states.
package cpu_6502_ISA_pkg;

   typedef enum logic [3:0] {
      IMPLIED,
      ACCUMULATOR,
      IMMEDIATE,
      ZERO_PAGE,
      ZERO_PAGE_X,
      ZERO_PAGE_Y,
      RELATIVE,
      ABSOLUTE,
      ABSOLUTE_X,
      ABSOLUTE_Y,
      ABSOLUTE_INDIRECT,
      INDEXED_INDIRECT,
      INDIRECT_INDEXED
   } addressing_mode_t;

   typedef logic [1:0] instr_len_t;

`ifdef CPU_6502_FETCH_RESET_VECTOR_EN
   typedef enum logic [2:0] {VEC_LO, VEC_HI, VEC_LD, OPC, B1, B2, B3, HOLD} fetch_state_t;
`else
   typedef enum logic [2:0] {OPC, B1, B2, B3, HOLD} fetch_state_t;
`endif

   localparam logic [15:0] RESET_VECTOR_LO = 16'hFFFC;
   localparam logic [15:0] RESET_VECTOR_HI = 16'hFFFD;
   localparam logic [7:0]  JSR             = 8'h20;
   localparam logic [7:0]  JMP_ABS_OPC     = 8'h4C;
   localparam logic [7:0]  JMP_IND_OPC     = 8'h6C;

   // Single-byte opcodes whose bit pattern would otherwise fall into the
   // cc/bbb grid (stack ops, flag ops, transfers, inc/dec of X/Y, NOP, BRK).
   function automatic logic is_implied_opcode(input logic [7:0] op);
      case (op)
         8'h00, 8'h08, 8'h18, 8'h28, 8'h38, 8'h40, 8'h48, 8'h58,
         8'h60, 8'h68, 8'h78, 8'h88, 8'h98, 8'hA8, 8'hB8, 8'hC8,
         8'hD8, 8'hE8, 8'hF8, 8'h8A, 8'h9A, 8'hAA, 8'hBA, 8'hCA,
         8'hEA:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_6502_fetch_if.sv
// cpu_6502_fetch_if -- bus bundle between the fetch unit, memory and decoder.
// master: the fetch unit (drives mem_addr_o/mem_rd_o and the instruction
//         outputs, receives mem_data_i, redirect and decoder ready).
// slave:  the memory/decoder side.
interface cpu_6502_fetch_if;
   import cpu_6502_ISA_pkg::*;

   logic [15:0]      mem_addr_o;
   logic             mem_rd_o;
   logic [7:0]       mem_data_i;
   logic             redirect_i;
   logic [15:0]      redirect_pc_i;
   logic             instr_valid_o;
   logic             instr_ready_i;
   logic [7:0]       opcode_o;
   logic [15:0]      operand_o;
   instr_len_t       instr_len_o;
   logic [15:0]      instr_pc_o;
   addressing_mode_t addr_mode_o;
   logic             illegal_o;

   modport master (
      output mem_addr_o, mem_rd_o, instr_valid_o, opcode_o, operand_o,
             instr_len_o, instr_pc_o, addr_mode_o, illegal_o,
      input  mem_data_i, redirect_i, redirect_pc_i, instr_ready_i
   );

   modport slave (
      input  mem_addr_o, mem_rd_o, instr_valid_o, opcode_o, operand_o,
             instr_len_o, instr_pc_o, addr_mode_o, illegal_o,
      output mem_data_i, redirect_i, redirect_pc_i, instr_ready_i
   );
endinterface

// File: rtl/cpu_6502_len_decode.sv
// cpu_6502_len_decode -- combinational 6502 length / addressing-mode decode.
// Ports: opcode (in, 8)  -> len (1..3), mode (addressing_mode_t),
//        illegal (opcode outside the documented groups; decodes as 1-byte implied).
module cpu_6502_len_decode
   import cpu_6502_ISA_pkg::*;
(
   input  logic [7:0]       opcode,
   output instr_len_t       len,
   output addressing_mode_t mode,
   output logic             illegal
);

   logic [1:0] cc;
   logic [2:0] bbb;
   logic       x_index_is_y;

   assign cc  = opcode[1:0];
   assign bbb = opcode[4:2];
   // STX/LDX (aaa=100/101) index with Y where the rest of the cc=10 group uses X.
   assign x_index_is_y = (opcode[7:5] == 3'b100) || (opcode[7:5] == 3'b101);

   // Special opcodes are matched first; only then is the regular cc/bbb grid used.
   always_comb begin
      len     = 2'd1;
      mode    = IMPLIED;
      illegal = 1'b0;
      if (is_implied_opcode(opcode)) begin
         len  = 2'd1;
         mode = IMPLIED;
      end else if (opcode[4:0] == 5'b10000) begin
         len  = 2'd2;
         mode = RELATIVE;
      end else if ((opcode == JSR) || (opcode == JMP_ABS_OPC)) begin
         len  = 2'd3;
         mode = ABSOLUTE;
      end else if (opcode == JMP_IND_OPC) begin
         len  = 2'd3;
         mode = ABSOLUTE_INDIRECT;
      end else begin
         case (cc)
            2'b01: begin
               case (bbb)
                  3'b000:  begin len = 2'd2; mode = INDEXED_INDIRECT; end
                  3'b001:  begin len = 2'd2; mode = ZERO_PAGE;        end
                  3'b010:  begin len = 2'd2; mode = IMMEDIATE;        end
                  3'b011:  begin len = 2'd3; mode = ABSOLUTE;         end
                  3'b100:  begin len = 2'd2; mode = INDIRECT_INDEXED; end
                  3'b101:  begin len = 2'd2; mode = ZERO_PAGE_X;      end
                  3'b110:  begin len = 2'd3; mode = ABSOLUTE_Y;       end
                  default: begin len = 2'd3; mode = ABSOLUTE_X;       end
               endcase
            end
            2'b10: begin
               case (bbb)
                  3'b000:  begin len = 2'd2; mode = IMMEDIATE;   end
                  3'b001:  begin len = 2'd2; mode = ZERO_PAGE;   end
                  3'b010:  begin len = 2'd1; mode = ACCUMULATOR; end
                  3'b011:  begin len = 2'd3; mode = ABSOLUTE;    end
                  3'b101:  begin len = 2'd2; mode = x_index_is_y ? ZERO_PAGE_Y : ZERO_PAGE_X; end
                  3'b111:  begin len = 2'd3; mode = x_index_is_y ? ABSOLUTE_Y  : ABSOLUTE_X;  end
                  default: illegal = 1'b1;
               endcase
            end
            2'b00: begin
               case (bbb)
                  3'b000:  begin len = 2'd2; mode = IMMEDIATE;   end
                  3'b001:  begin len = 2'd2; mode = ZERO_PAGE;   end
                  3'b011:  begin len = 2'd3; mode = ABSOLUTE;    end
                  3'b101:  begin len = 2'd2; mode = ZERO_PAGE_X; end
                  3'b111:  begin len = 2'd3; mode = ABSOLUTE_X;  end
                  default: illegal = 1'b1;
               endcase
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/cpu_6502_fetch.sv
// cpu_6502_fetch -- 6502 instruction fetch unit.
// Reads opcode and operand bytes from a memory with one-cycle read latency,
// decodes length/addressing mode and holds the instruction for the decoder
// until instr_ready_i. A redirect pulse restarts fetch at a new PC.
// Ports: clk_i, rst_i (async, active-high); bus (cpu_6502_fetch_if.master):
//   mem_addr_o/mem_rd_o/mem_data_i memory read port, redirect_i/redirect_pc_i
//   PC override, instr_valid_o/instr_ready_i decoder handshake, opcode_o,
//   operand_o, instr_len_o, instr_pc_o, addr_mode_o, illegal_o.
// Parameter RESET_PC: start PC when the vector fetch is not built in.
// Build option: CPU_6502_FETCH_RESET_VECTOR_EN loads the start PC from FFFC/FFFD.
module cpu_6502_fetch
   import cpu_6502_ISA_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'hC000
)(
   input  logic             clk_i,
   input  logic             rst_i,
   cpu_6502_fetch_if.master bus
);

`ifdef CPU_6502_FETCH_RESET_VECTOR_EN
   localparam fetch_state_t RESET_STATE = VEC_LO;
`else
   localparam fetch_state_t RESET_STATE = OPC;
`endif

   fetch_state_t     state, state_nxt;
   logic [15:0]      pc;
   logic [15:0]      instr_pc_r;
   logic [7:0]       opcode_r;
   logic [15:0]      operand_r;
   instr_len_t       len_r;
   addressing_mode_t mode_r;
   logic             illegal_r;
   instr_len_t       dec_len;
   addressing_mode_t dec_mode;
   logic             dec_illegal;
   logic             redirect_en;
   logic             mem_rd;
   logic [15:0]      mem_addr;

   // Decodes the byte arriving in B1, i.e. the opcode read issued in OPC.
   cpu_6502_len_decode u_len_decode (
      .opcode  (bus.mem_data_i),
      .len     (dec_len),
      .mode    (dec_mode),
      .illegal (dec_illegal)
   );

   // The vector load cannot be interrupted by a redirect.
`ifdef CPU_6502_FETCH_RESET_VECTOR_EN
   assign redirect_en = bus.redirect_i && !((state == VEC_LO) || (state == VEC_HI) || (state == VEC_LD));
`else
   assign redirect_en = bus.redirect_i;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= RESET_STATE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
`ifdef CPU_6502_FETCH_RESET_VECTOR_EN
         VEC_LO:  state_nxt = VEC_HI;
         VEC_HI:  state_nxt = VEC_LD;
         VEC_LD:  state_nxt = OPC;
`endif
         OPC:     state_nxt = B1;
         B1:      state_nxt = (dec_len == 2'd1) ? HOLD : B2;
         B2:      state_nxt = (len_r == 2'd2) ? HOLD : B3;
         B3:      state_nxt = HOLD;
         HOLD:    state_nxt = bus.instr_ready_i ? OPC : HOLD;
         default: state_nxt = OPC;
      endcase
      // A redirect in HOLD with ready also lands here: the held instruction
      // has been taken by the decoder, fetch just restarts elsewhere.
      if (redirect_en) state_nxt = OPC;
   end

   always_comb begin
      mem_rd   = 1'b0;
      mem_addr = pc;
      case (state)
`ifdef CPU_6502_FETCH_RESET_VECTOR_EN
         VEC_LO:  begin mem_rd = 1'b1; mem_addr = RESET_VECTOR_LO; end
         VEC_HI:  begin mem_rd = 1'b1; mem_addr = RESET_VECTOR_HI; end
`endif
         OPC:     mem_rd = 1'b1;
         B1:      mem_rd = (dec_len != 2'd1);
         B2:      mem_rd = (len_r == 2'd3);
         default: mem_rd = 1'b0;
      endcase
   end

   // Reset state OPC would otherwise strobe a read while reset is held.
   assign bus.mem_rd_o      = mem_rd && !rst_i;
   assign bus.mem_addr_o    = mem_addr;
   assign bus.instr_valid_o = (state == HOLD);
   assign bus.opcode_o      = opcode_r;
   assign bus.operand_o     = operand_r;
   assign bus.instr_len_o   = len_r;
   assign bus.instr_pc_o    = instr_pc_r;
   assign bus.addr_mode_o   = mode_r;
   assign bus.illegal_o     = illegal_r;

   // pc advances exactly when an instruction byte read is issued; a redirect
   // overrides any capture so stale read data never reaches the outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc         <= RESET_PC;
         instr_pc_r <= 16'h0000;
         opcode_r   <= 8'h00;
         operand_r  <= 16'h0000;
         len_r      <= 2'd1;
         mode_r     <= IMPLIED;
         illegal_r  <= 1'b0;
      end else if (redirect_en) begin
         pc <= bus.redirect_pc_i;
      end else begin
         case (state)
`ifdef CPU_6502_FETCH_RESET_VECTOR_EN
            VEC_HI: pc[7:0]  <= bus.mem_data_i;
            VEC_LD: pc[15:8] <= bus.mem_data_i;
`endif
            OPC: begin
               instr_pc_r <= pc;
               pc         <= pc + 16'd1;
            end
            B1: begin
               opcode_r  <= bus.mem_data_i;
               len_r     <= dec_len;
               mode_r    <= dec_mode;
               illegal_r <= dec_illegal;
               operand_r <= 16'h0000;
               if (dec_len != 2'd1) pc <= pc + 16'd1;
            end
            B2: begin
               operand_r[7:0] <= bus.mem_data_i;
               if (len_r == 2'd3) pc <= pc + 16'd1;
            end
            B3:      operand_r[15:8] <= bus.mem_data_i;
            default: ;
         endcase
      end
   end

endmodule
